// File: rtl/fifo_ser_pkg.sv
// Shared types for the FIFO width serializer.
// Holds the serializer FSM state encoding.
package fifo_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } ser_state_t;

endpackage

// File: rtl/fifo_width_serializer.sv
// Drains IN_WIDTH-bit FIFO words and emits them MSB-first as
// IN_WIDTH/OUT_WIDTH narrower beats on a valid/ready stream.
//
// Ports:
//   clk        rising-edge clock, shared with the FIFO
//   resetn     asynchronous active-low reset
//   fifo_empty FIFO empty flag
//   fifo_r_en  FIFO read enable (combinational)
//   fifo_d_out FIFO read data, valid the cycle after a read
//   m_valid    output beat valid
//   m_ready    downstream ready
//   m_data     output beat
//   m_last     final beat of a word
//   busy       high whenever the FSM is not idle
module fifo_width_serializer
  import fifo_ser_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 fifo_empty,
  output logic                 fifo_r_en,
  input  logic [IN_WIDTH-1:0]  fifo_d_out,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_last,
  output logic                 busy
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = $clog2(RATIO);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  generate
    if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_width
      $fatal(1, "fifo_width_serializer: bad IN_WIDTH/OUT_WIDTH");
    end
  endgenerate

  ser_state_t          state_q;
  ser_state_t          state_d;
  logic [IN_WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                fire;
  logic                last_beat;

  assign m_valid   = (state_q == SEND);
  assign busy      = (state_q != IDLE);
  assign fire      = m_valid && m_ready;
  assign last_beat = (cnt_q == LAST_CNT);
  assign m_last    = m_valid && last_beat;

  // Gated so the idle beat bus reads zero rather than the
  // stale final nibble of the previous word.
  assign m_data = m_valid ? shreg_q[IN_WIDTH-1 -: OUT_WIDTH]
                          : '0;

  // Reads only from IDLE or on the last-beat handshake, and
  // never into an empty FIFO: one pop per word.
  always_comb begin
    state_d   = state_q;
    fifo_r_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_r_en = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        state_d = SEND;
      end
      SEND: begin
        if (fire && last_beat) begin
          if (!fifo_empty) begin
            fifo_r_en = 1'b1;
            state_d   = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH) begin
        shreg_q <= fifo_d_out;
        cnt_q   <= '0;
      end else if (fire && !last_beat) begin
        shreg_q <= shreg_q << OUT_WIDTH;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_width_serializer.sv
// Self-checking bench for fifo_width_serializer.
// Scoreboard of expected beats fed from a behavioural FIFO.
module tb_fifo_width_serializer;

  logic        clk;
  logic        resetn;

  logic        fifo_empty;
  logic        fifo_r_en;
  logic [15:0] fifo_d_out;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  m_data;
  logic        m_last;
  logic        busy;

  logic        fifo_empty2;
  logic        fifo_r_en2;
  logic [7:0]  fifo_d_out2;
  logic        m_valid2;
  logic        m_ready2;
  logic [1:0]  m_data2;
  logic        m_last2;
  logic        busy2;

  fifo_width_serializer u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .fifo_empty (fifo_empty),
    .fifo_r_en  (fifo_r_en),
    .fifo_d_out (fifo_d_out),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy)
  );

  fifo_width_serializer #(
    .IN_WIDTH  (8),
    .OUT_WIDTH (2)
  ) u_dut2 (
    .clk        (clk),
    .resetn     (resetn),
    .fifo_empty (fifo_empty2),
    .fifo_r_en  (fifo_r_en2),
    .fifo_d_out (fifo_d_out2),
    .m_valid    (m_valid2),
    .m_ready    (m_ready2),
    .m_data     (m_data2),
    .m_last     (m_last2),
    .busy       (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0] fq[$];
  logic [7:0]  fq2[$];
  logic [4:0]  exp1[$];
  logic [2:0]  exp2[$];
  int          rd_cyc[$];
  int          hs_cyc[$];
  int          rd2_cyc[$];
  int          hs2_cyc[$];

  logic        stall_prev;
  logic [3:0]  pdata;
  logic        plast;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  task automatic push1(input logic [15:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
    for (int b = 0; b < 4; b++) begin
      logic [15:0] sh;
      sh = w >> (12 - 4 * b);
      exp1.push_back({(b == 3), sh[3:0]});
    end
  endtask

  task automatic push2(input logic [7:0] w);
    fq2.push_back(w);
    fifo_empty2 = 1'b0;
    for (int b = 0; b < 4; b++) begin
      logic [7:0] sh;
      sh = w >> (6 - 2 * b);
      exp2.push_back({(b == 3), sh[1:0]});
    end
  endtask

  task automatic sample();
    logic [4:0] e;
    logic [2:0] e2;
    if (stall_prev) begin
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_data", 32'(m_data), 32'(pdata));
      check("hold_last", 32'(m_last), 32'(plast));
    end
    stall_prev = m_valid && !m_ready;
    pdata = m_data;
    plast = m_last;
    if (fifo_r_en) rd_cyc.push_back(cyc);
    if (fifo_r_en && fifo_empty)
      check("ren_when_empty", 32'(fifo_r_en), 32'd0);
    if (m_valid && m_ready) begin
      hs_cyc.push_back(cyc);
      if (exp1.size() == 0) begin
        check("extra_beat", 32'(m_valid), 32'd0);
      end else begin
        e = exp1.pop_front();
        check("beat_data", 32'(m_data), 32'(e[3:0]));
        check("beat_last", 32'(m_last), 32'(e[4]));
      end
    end
    if (fifo_r_en2) rd2_cyc.push_back(cyc);
    if (fifo_r_en2 && fifo_empty2)
      check("ren2_when_empty", 32'(fifo_r_en2), 32'd0);
    if (m_valid2 && m_ready2) begin
      hs2_cyc.push_back(cyc);
      if (exp2.size() == 0) begin
        check("extra_beat2", 32'(m_valid2), 32'd0);
      end else begin
        e2 = exp2.pop_front();
        check("beat2_data", 32'(m_data2), 32'(e2[1:0]));
        check("beat2_last", 32'(m_last2), 32'(e2[2]));
      end
    end
  endtask

  // Called at a negedge; samples settled outputs, then models the
  // FIFO's registered read port one step after the edge.
  task automatic tick();
    logic pop1;
    logic pop2;
    #1;
    sample();
    pop1 = fifo_r_en && !fifo_empty;
    pop2 = fifo_r_en2 && !fifo_empty2;
    @(posedge clk);
    cyc++;
    #1;
    if (pop1) fifo_d_out = fq.pop_front();
    if (pop2) fifo_d_out2 = fq2.pop_front();
    fifo_empty  = (fq.size() == 0);
    fifo_empty2 = (fq2.size() == 0);
    @(negedge clk);
  endtask

  task automatic clear_logs();
    rd_cyc.delete();
    hs_cyc.delete();
    rd2_cyc.delete();
    hs2_cyc.delete();
  endtask

  task automatic drain1(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (!busy && exp1.size() == 0 && fifo_empty) break;
      tick();
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_pending"}, 32'(exp1.size()), 32'd0);
  endtask

  task automatic drain2(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (!busy2 && exp2.size() == 0 && fifo_empty2) break;
      tick();
    end
    check({tag, "_idle"}, 32'(busy2), 32'd0);
    check({tag, "_pending"}, 32'(exp2.size()), 32'd0);
  endtask

  initial begin
    resetn      = 1'b0;
    m_ready     = 1'b1;
    m_ready2    = 1'b1;
    fifo_empty  = 1'b1;
    fifo_empty2 = 1'b1;
    fifo_d_out  = '0;
    fifo_d_out2 = '0;
    stall_prev  = 1'b0;
    pdata       = '0;
    plast       = 1'b0;

    #2;
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ren", 32'(fifo_r_en), 32'd0);
    check("rst_valid2", 32'(m_valid2), 32'd0);
    @(negedge clk);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // single word
    clear_logs();
    push1(16'hA5C3);
    drain1("single");
    check("single_reads", 32'(rd_cyc.size()), 32'd1);
    check("single_beats", 32'(hs_cyc.size()), 32'd4);
    check("single_latency",
          32'(qat(hs_cyc, 0) - qat(rd_cyc, 0)), 32'd2);
    check("single_span",
          32'(qat(hs_cyc, 3) - qat(hs_cyc, 0)), 32'd3);

    // back-to-back words with prefetch
    clear_logs();
    push1(16'h1234);
    push1(16'hBEEF);
    drain1("b2b");
    check("b2b_reads", 32'(rd_cyc.size()), 32'd2);
    check("b2b_beats", 32'(hs_cyc.size()), 32'd8);
    check("b2b_prefetch",
          32'(qat(rd_cyc, 1) - qat(hs_cyc, 3)), 32'd0);
    check("b2b_bubble",
          32'(qat(hs_cyc, 4) - qat(hs_cyc, 3)), 32'd2);
    check("b2b_total",
          32'(qat(hs_cyc, 7) - qat(rd_cyc, 0)), 32'd10);

    // backpressure during beat 0x5
    clear_logs();
    push1(16'hA5C3);
    for (int i = 0; i < 10; i++) begin
      if (m_valid && m_data == 4'h5) break;
      tick();
    end
    check("bp_reach5", 32'(m_data), 32'h5);
    m_ready = 1'b0;
    repeat (3) tick();
    m_ready = 1'b1;
    drain1("bp");
    check("bp_beats", 32'(hs_cyc.size()), 32'd4);
    check("bp_gap",
          32'(qat(hs_cyc, 1) - qat(hs_cyc, 0)), 32'd4);
    check("bp_reads", 32'(rd_cyc.size()), 32'd1);

    // empty FIFO stays idle
    clear_logs();
    for (int i = 0; i < 20; i++) begin
      tick();
      check("empty_ren", 32'(fifo_r_en), 32'd0);
      check("empty_valid", 32'(m_valid), 32'd0);
      check("empty_busy", 32'(busy), 32'd0);
    end

    // reset mid-word
    clear_logs();
    push1(16'hA5C3);
    for (int i = 0; i < 10; i++) begin
      if (hs_cyc.size() >= 1) break;
      tick();
    end
    check("mid_first_beat", 32'(hs_cyc.size()), 32'd1);
    resetn = 1'b0;
    #1;
    check("mid_valid", 32'(m_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_data", 32'(m_data), 32'd0);
    check("mid_last", 32'(m_last), 32'd0);
    check("mid_ren", 32'(fifo_r_en), 32'd0);
    exp1.delete();
    stall_prev = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    clear_logs();
    push1(16'h0F0F);
    drain1("after_rst");
    check("after_rst_beats", 32'(hs_cyc.size()), 32'd4);

    // narrow instance: 8-bit words as 2-bit beats
    clear_logs();
    push2(8'hE4);
    drain2("sweep");
    check("sweep_beats", 32'(hs2_cyc.size()), 32'd4);
    check("sweep_reads", 32'(rd2_cyc.size()), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_width_serializer.md
# fifo_width_serializer

Read-side drain stage for the team's synchronous FIFO. It pops IN_WIDTH-bit words from the FIFO and emits each word as IN_WIDTH/OUT_WIDTH narrower beats, MSB-first, on a valid/ready stream. It sits directly downstream of the FIFO, driving its read enable and consuming its registered read-data output.

## Interface
- IN_WIDTH, 16, FIFO word width; must equal the FIFO data width.
- OUT_WIDTH, 4, output beat width; IN_WIDTH must be an integer multiple of OUT_WIDTH, with ratio ≥ 2.
- RATIO, IN_WIDTH/OUT_WIDTH, beats per word; derived, not overridden.
- CNT_W, $clog2(RATIO), beat-counter width.

Ports:
- clk  in  1  rising-edge clock, shared with the FIFO.
- resetn  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_r_en  out  1  FIFO read enable; combinational.
- fifo_d_out  in  IN_WIDTH  FIFO read data, valid the cycle after an accepted read.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  OUT_WIDTH  output beat.
- m_last  out  1  marks the final beat of a word.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, FETCH, SEND.
- IDLE:
  - fifo_r_en = !fifo_empty.
  - If !fifo_empty, go to FETCH.
- FETCH (FIFO read data now valid):
  - Load fifo_d_out into shift register shreg.
  - Clear beat counter cnt; go to SEND.
  - fifo_r_en = 0.
- SEND:
  - m_valid = 1.
  - m_data = shreg[IN_WIDTH-1 -: OUT_WIDTH].
  - m_last = (cnt == RATIO-1).
- Handshake in SEND (m_valid && m_ready):
  - Not last beat: shreg <= shreg << OUT_WIDTH; cnt <= cnt+1; stay in SEND.
  - Last beat with !fifo_empty: fifo_r_en = 1 in the same cycle; go to FETCH (prefetch).
  - Last beat with fifo_empty: go to IDLE; fifo_r_en = 0.
- fifo_r_en is never asserted while fifo_empty = 1, and never in FETCH. This guarantees exactly one FIFO pop per word.
- Zero-fill on shift; cnt wraps only via reload in FETCH.
- m_valid and m_ready are combinationally independent. m_valid depends on state only.

## Timing
- Reset (asynchronous, resetn = 0):
  - state = IDLE, shreg = 0, cnt = 0.
  - m_valid = 0, m_last = 0, m_data = 0, busy = 0, fifo_r_en = 0.
  - Takes effect immediately, mid-word included.
  - Any partially sent word is dropped, not replayed.
  - A FIFO read accepted on the reset edge is lost; the bench accounts for it.
- Latency from fifo_empty falling (in IDLE) to first m_valid is 2 cycles:
  - cycle 0: read issued.
  - cycle 1: FETCH.
  - cycle 2: SEND.
- Sustained throughput with m_ready tied high and a non-empty FIFO is RATIO beats per RATIO+1 cycles (one FETCH bubble per word).
- Backpressure: while m_valid && !m_ready, m_data, m_last and state hold stable. No beat may change or drop.
- Simultaneous events:
  - Last-beat handshake with fifo_empty deasserting in the same cycle: fifo_empty is sampled that cycle. If it is 1, go to IDLE, and IDLE issues the read the next cycle.
  - m_ready toggling in FETCH is ignored.

## Structure
- Shared package fifo_ser_pkg holds:
  - typedef enum of ser_state_t {IDLE, FETCH, SEND}.
  - No other constants; widths stay as module parameters.
- No sub-module: FSM, shifter and counter sit in one module of about 150 lines.
- Elaboration-time check: IN_WIDTH % OUT_WIDTH == 0 and RATIO ≥ 2, otherwise $fatal.

## Test plan
- Single word: FIFO holds 0xA5C3, m_ready = 1 → beats 0xA, 0x5, 0xC, 0x3 on consecutive cycles; m_last only with 0x3; exactly one fifo_r_en pulse; returns to IDLE.
- Back-to-back: words 0x1234, 0xBEEF queued, m_ready = 1 → beats 1,2,3,4,(bubble),B,E,E,F; the second fifo_r_en coincides with beat 4's handshake; 10 cycles from the first read to the last beat.
- Backpressure: 0xA5C3, with m_ready low for 3 cycles during beat 0x5 → m_data holds 0x5 for 4 cycles; full sequence intact.
- Empty FIFO: fifo_empty = 1 for 20 cycles → fifo_r_en = 0, m_valid = 0, busy = 0 throughout.
- Reset mid-word: resetn low after beat 0xA of 0xA5C3 → m_valid drops immediately; after release with FIFO holding 0x0F0F → beats 0,F,0,F.
- Parameter sweep with IN_WIDTH = 8, OUT_WIDTH = 2: word 0xE4 → beats 3,2,1,0, with m_last on 0.
